// File: rtl/systolic_result_collector_if.sv
// Bundle between the dense_mult result lanes, the de-skew collector and the
// row-major result consumer.
interface systolic_result_collector_if #(
  parameter int N            = 3,
  parameter int OUTPUT_WIDTH = 16
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Lane side has no backpressure: valid_bit_s_in[l] qualifies s_in_bus[l] for one cycle.
  // Stream side: a beat transfers on a rising edge where m_valid & m_ready; while
  // m_valid is high and m_ready low, m_data/m_row/m_col/m_last hold steady.
  logic [OUTPUT_WIDTH-1:0] s_in_bus [0:2*N-2];
  logic [0:2*N-2]          valid_bit_s_in;
  logic [OUTPUT_WIDTH-1:0] m_data;
  logic [IDX_W-1:0]        m_row;
  logic [IDX_W-1:0]        m_col;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_last;
  logic                    busy;
  logic                    err_overflow;
  logic                    err_drop;

  modport master (
    input  s_in_bus, valid_bit_s_in, m_ready,
    output m_data, m_row, m_col, m_valid, m_last, busy, err_overflow, err_drop
  );

  modport slave (
    output s_in_bus, valid_bit_s_in, m_ready,
    input  m_data, m_row, m_col, m_valid, m_last, busy, err_overflow, err_drop
  );
endinterface

// File: rtl/systolic_result_collector.sv
// De-skews the diagonal result lanes of an NxN systolic array into a matrix
// buffer, then streams the matrix out row-major over valid/ready.
module systolic_result_collector #(
  parameter int N            = 3,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  systolic_result_collector_if.master bus
);
  localparam int LANES  = 2 * N - 1;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int LCNT_W = $clog2(N + 1);
  localparam int TCNT_W = $clog2(N * N + 1);
  localparam logic [TCNT_W-1:0] TOTAL    = TCNT_W'(N * N);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [LCNT_W-1:0]       lane_cnt_q [LANES];
  logic [LCNT_W-1:0]       lane_cnt_d [LANES];
  logic [TCNT_W-1:0]       total_q, total_d;
  logic [IDX_W-1:0]        row_q, row_d;
  logic [IDX_W-1:0]        col_q, col_d;
  logic                    ovf_q, ovf_d;
  logic                    drop_q, drop_d;
  logic [OUTPUT_WIDTH-1:0] mat_q [N][N];
  logic [OUTPUT_WIDTH-1:0] mat_d [N][N];
  logic [IDX_W-1:0]        wr_row, wr_col;
  logic                    at_last;
  logic                    draining;

  // Number of elements lane l carries: diagonal length N - |l-(N-1)|.
  function automatic logic [LCNT_W-1:0] lane_expect(input int l);
    int d;
    d = l - (N - 1);
    if (d < 0) d = -d;
    return LCNT_W'(N - d);
  endfunction

  // First row touched by lane l (lower-left diagonals start below row 0).
  function automatic int lane_row_off(input int l);
    return (l < N - 1) ? (N - 1 - l) : 0;
  endfunction

  assign draining = (state_q == DRAIN);
  assign at_last  = (row_q == LAST_IDX) && (col_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    total_d    = total_q;
    row_d      = row_q;
    col_d      = col_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    mat_d      = mat_q;
    wr_row     = '0;
    wr_col     = '0;
    case (state_q)
      COLLECT: begin
        for (int l = 0; l < LANES; l++) begin
          if (bus.valid_bit_s_in[l]) begin
            if (lane_cnt_q[l] < lane_expect(l)) begin
              wr_row = IDX_W'(int'(lane_cnt_q[l]) + lane_row_off(l));
              wr_col = IDX_W'(int'(lane_cnt_q[l]) + lane_row_off(l) + l - (N - 1));
              mat_d[wr_row][wr_col] = bus.s_in_bus[l];
              lane_cnt_d[l] = lane_cnt_q[l] + LCNT_W'(1);
              total_d       = total_d + TCNT_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        if (total_d == TOTAL) begin
          state_d = DRAIN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      DRAIN: begin
        // The buffer is frozen while draining; any lane traffic is lost.
        if (|bus.valid_bit_s_in) drop_d = 1'b1;
        if (bus.m_ready) begin
          if (at_last) begin
            state_d = COLLECT;
            row_d   = '0;
            col_d   = '0;
            total_d = '0;
            for (int l = 0; l < LANES; l++) lane_cnt_d[l] = '0;
          end else if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = row_q + IDX_W'(1);
          end else begin
            col_d = col_q + IDX_W'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      total_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
      for (int l = 0; l < LANES; l++) lane_cnt_q[l] <= '0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      lane_cnt_q <= lane_cnt_d;
    end
  end

  // Buffer contents after reset are don't-care, so the array carries no reset.
  always_ff @(posedge clk) begin
    mat_q <= mat_d;
  end

  assign bus.m_valid      = draining;
  assign bus.m_data       = draining ? mat_q[row_q][col_q] : '0;
  assign bus.m_row        = draining ? row_q : '0;
  assign bus.m_col        = draining ? col_q : '0;
  assign bus.m_last       = draining && at_last;
  assign bus.busy         = draining;
  assign bus.err_overflow = ovf_q;
  assign bus.err_drop     = drop_q;
endmodule
